// File: rtl/routing_pkg.sv
// Shared routing-table definitions: entry geometry, entry field offsets and
// the loader state type. Also consumed by unified_routing_engine.
package routing_pkg;

  localparam int unsigned ENTRY_WIDTH     = 256;
  localparam int unsigned WORD_WIDTH      = 32;
  localparam int unsigned MAX_ENTRIES     = 64;
  localparam int unsigned WORDS_PER_ENTRY = ENTRY_WIDTH / WORD_WIDTH;

  // Bit offsets of the fields inside one routing entry
  localparam int unsigned DST_IP_LSB      = 0;
  localparam int unsigned DST_IP_MSB      = 31;
  localparam int unsigned VALID_BIT       = 32;
  localparam int unsigned DIRECT_HOST_BIT = 40;
  localparam int unsigned BROADCAST_BIT   = 48;
  localparam int unsigned OUT_PORT_LSB    = 64;
  localparam int unsigned OUT_PORT_MSB    = 79;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FLUSH,
    DONE
  } load_state_t;

endpackage

// File: rtl/route_table_loader.sv
// Route table loader: assembles streamed words into routing entries, writes
// them to the table in order, then zero-fills every unused address. Malformed
// streams (short final entry, too many entries) load an all-zero table and
// raise a sticky error.
module route_table_loader #(
  parameter int unsigned ENTRY_WIDTH = routing_pkg::ENTRY_WIDTH,
  parameter int unsigned WORD_WIDTH  = routing_pkg::WORD_WIDTH,
  parameter int unsigned MAX_ENTRIES = routing_pkg::MAX_ENTRIES
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cfg_start,
  input  logic [WORD_WIDTH-1:0]                s_data,
  input  logic                                 s_valid,
  input  logic                                 s_last,
  output logic                                 s_ready,
  output logic                                 init_mode,
  output logic [ENTRY_WIDTH-1:0]               init_entry_data,
  output logic [$clog2(MAX_ENTRIES)-1:0]       init_entry_addr,
  output logic                                 init_entry_wr,
  output logic                                 load_busy,
  output logic                                 load_done,
  output logic                                 load_error,
  output logic [$clog2(MAX_ENTRIES+1)-1:0]     entry_count
);

  localparam int unsigned WORDS  = ENTRY_WIDTH / WORD_WIDTH;
  localparam int unsigned IDX_W  = $clog2(WORDS);
  localparam int unsigned ADDR_W = $clog2(MAX_ENTRIES);
  localparam int unsigned CNT_W  = $clog2(MAX_ENTRIES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_ENTRIES);

  routing_pkg::load_state_t state;
  logic [IDX_W-1:0]              word_idx;
  // Holds words 0..WORDS-2; the final word is taken straight from s_data.
  logic [ENTRY_WIDTH-WORD_WIDTH-1:0] asm_buf;
  // Next zero-fill address; kept apart so entry_count reports loaded entries.
  logic [CNT_W-1:0]              flush_addr;

  // Stream handshake and engine-blocking flags decode directly from state
  assign s_ready   = (state == routing_pkg::LOAD) || (state == routing_pkg::DRAIN);
  assign init_mode = (state == routing_pkg::LOAD) || (state == routing_pkg::DRAIN) ||
                     (state == routing_pkg::FLUSH);
  assign load_busy = (state != routing_pkg::IDLE);

  // Load sequencer: assembly, table writes, zero-fill and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= routing_pkg::IDLE;
      word_idx        <= '0;
      asm_buf         <= '0;
      flush_addr      <= '0;
      init_entry_data <= '0;
      init_entry_addr <= '0;
      init_entry_wr   <= 1'b0;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
      entry_count     <= '0;
    end else begin
      init_entry_wr <= 1'b0;
      load_done     <= 1'b0;
      case (state)
        routing_pkg::IDLE: begin
          if (cfg_start) begin
            state       <= routing_pkg::LOAD;
            entry_count <= '0;
            word_idx    <= '0;
            load_error  <= 1'b0;
          end
        end

        routing_pkg::LOAD: begin
          if (s_valid) begin
            if (entry_count == FULL_CNT) begin
              // Table already full and the stream keeps going
              load_error  <= 1'b1;
              entry_count <= '0;
              word_idx    <= '0;
              flush_addr  <= '0;
              state       <= s_last ? routing_pkg::FLUSH : routing_pkg::DRAIN;
            end else if (word_idx == LAST_IDX) begin
              init_entry_wr   <= 1'b1;
              init_entry_data <= {s_data, asm_buf};
              init_entry_addr <= entry_count[ADDR_W-1:0];
              entry_count     <= entry_count + 1'b1;
              word_idx        <= '0;
              if (s_last) begin
                flush_addr <= entry_count + 1'b1;
                state      <= routing_pkg::FLUSH;
              end
            end else if (s_last) begin
              // Stream ended mid-entry: drop the partial entry
              load_error  <= 1'b1;
              entry_count <= '0;
              word_idx    <= '0;
              flush_addr  <= '0;
              state       <= routing_pkg::FLUSH;
            end else begin
              asm_buf[int'(word_idx) * WORD_WIDTH +: WORD_WIDTH] <= s_data;
              word_idx <= word_idx + 1'b1;
            end
          end
        end

        routing_pkg::DRAIN: begin
          if (s_valid && s_last) begin
            flush_addr <= '0;
            state      <= routing_pkg::FLUSH;
          end
        end

        routing_pkg::FLUSH: begin
          if (flush_addr == FULL_CNT) begin
            load_done <= 1'b1;
            state     <= routing_pkg::DONE;
          end else begin
            init_entry_wr   <= 1'b1;
            init_entry_data <= '0;
            init_entry_addr <= flush_addr[ADDR_W-1:0];
            flush_addr      <= flush_addr + 1'b1;
          end
        end

        routing_pkg::DONE: begin
          state <= routing_pkg::IDLE;
        end

        default: state <= routing_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_route_table_loader.sv
// Self-checking bench for route_table_loader: table of load scenarios plus
// randomized loads, checked against an entry-level model of the table image.
module tb_route_table_loader;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_start = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic         init_mode;
  logic [255:0] init_entry_data;
  logic [5:0]   init_entry_addr;
  logic         init_entry_wr;
  logic         load_busy;
  logic         load_done;
  logic         load_error;
  logic [6:0]   entry_count;

  route_table_loader #(
    .ENTRY_WIDTH(256),
    .WORD_WIDTH (32),
    .MAX_ENTRIES(64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_start      (cfg_start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .init_mode      (init_mode),
    .init_entry_data(init_entry_data),
    .init_entry_addr(init_entry_addr),
    .init_entry_wr  (init_entry_wr),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_error     (load_error),
    .entry_count    (entry_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0]   addr;
    logic [255:0] data;
    int           cyc;
  } wr_t;

  typedef struct {
    logic [5:0]   addr;
    logic [255:0] data;
    int           src;   // index of the word completing the entry, -1 for fill
  } exp_t;

  typedef struct {
    int nw;          // words streamed, s_last on the final one
    int mode;        // 0 continuous, 1 valid every other cycle, 2 random gaps
    bit poke;        // pulse cfg_start mid-load (must be ignored)
    bit fixed;       // deterministic data pattern
    int exp_count;
    bit exp_err;
  } scen_t;

  wr_t  wq[$];
  exp_t ew[$];
  int   acc[$];
  int   dq[$];
  bit   mon_en = 1'b0;
  logic [31:0] words [0:599];

  // Observe the table write port, handshakes and completion pulses
  always @(negedge clk) begin
    if (mon_en) begin
      if (init_entry_wr) wq.push_back('{init_entry_addr, init_entry_data, cyc});
      if (s_valid && s_ready) acc.push_back(cyc);
      if (load_done) dq.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Table image expected from the stream: whole entries in order, then zeros;
  // any malformed stream leaves the whole table zeroed and the count at 0.
  task automatic build_expect(input int nw, output int n_ent, output int ecount, output bit eerr);
    int first_zero;
    ew.delete();
    if (nw > 64 * 8) begin
      n_ent = 64; eerr = 1'b1; ecount = 0;
    end else if (nw % 8 != 0) begin
      n_ent = nw / 8; eerr = 1'b1; ecount = 0;
    end else begin
      n_ent = nw / 8; eerr = 1'b0; ecount = n_ent;
    end
    for (int e = 0; e < n_ent; e++) begin
      logic [255:0] d;
      for (int k = 0; k < 8; k++) d[32*k +: 32] = words[8*e + k];
      ew.push_back('{6'(e), d, 8*e + 7});
    end
    first_zero = ecount;
    for (int a = first_zero; a < 64; a++) ew.push_back('{6'(a), 256'd0, -1});
  endtask

  task automatic fill_words(input int nw, input bit fixed);
    for (int k = 0; k < nw; k++) begin
      if (fixed) words[k] = (k == 0) ? 32'h0A00_0001 : 32'h1000_0000 + 32'(k) * 32'h0101_0101;
      else       words[k] = $urandom;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the final word is taken
  task automatic drive_stream(input int nw, input int mode, input bit poke, input bit with_last);
    int i = 0;
    int t = 0;
    bit v;
    while (i < nw) begin
      if (t >= 3000) begin
        total++; bad++;
        $display("FAIL stream_budget actual=%0d words required=%0d words", i, nw);
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = ($urandom_range(2) != 0);
      endcase
      s_valid   = v;
      s_data    = words[i];
      s_last    = with_last && (i == nw - 1);
      cfg_start = poke && (t == 5);
      @(negedge clk);
      if (v && s_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    s_valid = 1'b0; s_last = 1'b0; cfg_start = 1'b0;
  endtask

  task automatic start_load();
    wq.delete(); acc.delete(); dq.delete();
    mon_en = 1'b1;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("start_s_ready", s_ready, 1);
    chk("start_init_mode", init_mode, 1);
    chk("start_load_error_cleared", load_error, 0);
    chk("start_entry_count", entry_count, 0);
  endtask

  task automatic run_scen(input scen_t s, input bit use_model_final);
    int n_ent, ecount, nchk;
    bit eerr;
    fill_words(s.nw, s.fixed);
    build_expect(s.nw, n_ent, ecount, eerr);
    start_load();
    drive_stream(s.nw, s.mode, s.poke, 1'b1);
    for (int c = 0; c < 300 && dq.size() == 0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("write_count", wq.size(), ew.size());
    nchk = (wq.size() < ew.size()) ? wq.size() : ew.size();
    for (int j = 0; j < nchk; j++) begin
      chk($sformatf("wr%0d_addr", j), wq[j].addr, ew[j].addr);
      chk($sformatf("wr%0d_data", j), wq[j].data, ew[j].data);
      if (ew[j].src >= 0 && ew[j].src < acc.size())
        chk($sformatf("wr%0d_cycle", j), wq[j].cyc, acc[ew[j].src] + 1);
    end
    chk("done_pulses", dq.size(), 1);
    if (dq.size() > 0 && wq.size() > 0)
      chk("done_after_last_write", dq[0], wq[wq.size()-1].cyc + 1);
    if (use_model_final) begin
      chk("entry_count", entry_count, ecount);
      chk("load_error", load_error, eerr);
    end else begin
      chk("entry_count", entry_count, s.exp_count);
      chk("load_error", load_error, s.exp_err);
    end
    chk("end_busy", load_busy, 0);
    chk("end_init_mode", init_mode, 0);
    chk("end_s_ready", s_ready, 0);
    mon_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_init_mode"}, init_mode, 0);
    chk({tag, "_wr"}, init_entry_wr, 0);
    chk({tag, "_data"}, init_entry_data, 0);
    chk({tag, "_addr"}, init_entry_addr, 0);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_error"}, load_error, 0);
    chk({tag, "_count"}, entry_count, 0);
  endtask

  scen_t tbl[8];

  initial begin
    tbl[0] = '{16,  0, 1'b0, 1'b1, 2,  1'b0};  // two entries, continuous
    tbl[1] = '{512, 0, 1'b0, 1'b0, 64, 1'b0};  // full table, no fill
    tbl[2] = '{14,  0, 1'b0, 1'b0, 0,  1'b1};  // s_last on word 5 of entry 1
    tbl[3] = '{520, 0, 1'b0, 1'b0, 0,  1'b1};  // 65 entries, overflow + drain
    tbl[4] = '{16,  1, 1'b0, 1'b1, 2,  1'b0};  // valid toggled, same data as row 0
    tbl[5] = '{24,  2, 1'b1, 1'b0, 3,  1'b0};  // gaps and a stray cfg_start
    tbl[6] = '{8,   0, 1'b0, 1'b0, 1,  1'b0};  // single entry
    tbl[7] = '{1,   0, 1'b0, 1'b0, 0,  1'b1};  // s_last on the very first word

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 8; r++) begin
      run_scen(tbl[r], 1'b0);
      if (r == 4 && wq.size() > 0) begin
        logic [255:0] d0;
        d0 = wq[0].data;
        chk("toggle_dst_ip", d0[31:0], 32'h0A00_0001);
      end
    end

    for (int r = 0; r < 6; r++) begin
      scen_t s;
      s.nw = (r == 5) ? 8 * int'($urandom_range(60, 66)) : int'($urandom_range(1, 48));
      s.mode = 2; s.poke = 1'b0; s.fixed = 1'b0; s.exp_count = 0; s.exp_err = 1'b0;
      run_scen(s, 1'b1);
    end

    // Reset during assembly of entry 2, then a clean reload
    fill_words(19, 1'b0);
    start_load();
    drive_stream(19, 0, 1'b0, 1'b0);
    wq.delete();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_writes", wq.size(), 0);
    rst_n = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    run_scen(tbl[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
